// File: rtl/ir_pkg.sv
// Shared types and constants for the IR frame decoder.
//   ir_state_t    : frame FSM states
//   pulse_class_t : classification of a completed high pulse
//   inverse_ok    : NEC integrity check (each inverse byte is the complement
//                   of the byte just before it)
package ir_pkg;

    typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} ir_state_t;
    typedef enum logic [1:0] {CLS_ZERO, CLS_ONE, CLS_LEADER, CLS_ERR} pulse_class_t;

    localparam int DEFAULT_FRAME_BITS = 32;
    localparam int ADDR_W             = 8;
    localparam int CMD_W              = 8;

    function automatic logic inverse_ok(input logic [31:0] f);
        return (f[15:8] == ~f[7:0]) && (f[31:24] == ~f[23:16]);
    endfunction

endpackage

// File: rtl/ir_pulse_classifier.sv
// Synchronizes the raw IR line, detects the end of each high pulse and
// reports the largest threshold class the pulse reached.
//   clk, rst_n   : clock, async active-low reset
//   ir           : raw IR line (asynchronous)
//   pulse_data   : counter level, pulse long enough for a logic 1
//   pulse_read   : counter level, pulse long enough for a leader
//   pulse_error  : counter level, pulse long enough to be an abort
//   pulse_end    : one cycle, the cycle after the synchronized line fell
//   pulse_class  : class of the pulse that just ended (valid with pulse_end)
module ir_pulse_classifier
    import ir_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ir,
    input  logic         pulse_data,
    input  logic         pulse_read,
    input  logic         pulse_error,
    output logic         pulse_end,
    output pulse_class_t pulse_class
);

    logic ir_meta;
    logic ir_s;
    logic ir_d;
    logic st_data;
    logic st_read;
    logic st_err;

    assign pulse_end = ir_d & ~ir_s;

    // The counter drops its levels the moment ir falls, which is several
    // cycles before the synchronized edge, so the levels are held sticky
    // until the pulse has been consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_meta <= 1'b0;
            ir_s    <= 1'b0;
            ir_d    <= 1'b0;
            st_data <= 1'b0;
            st_read <= 1'b0;
            st_err  <= 1'b0;
        end else begin
            ir_meta <= ir;
            ir_s    <= ir_meta;
            ir_d    <= ir_s;
            if (pulse_end) begin
                st_data <= 1'b0;
                st_read <= 1'b0;
                st_err  <= 1'b0;
            end else begin
                st_data <= st_data | pulse_data;
                st_read <= st_read | pulse_read;
                st_err  <= st_err  | pulse_error;
            end
        end
    end

    always_comb begin
        pulse_class = CLS_ZERO;
        if (st_err)
            pulse_class = CLS_ERR;
        else if (st_read)
            pulse_class = CLS_LEADER;
        else if (st_data)
            pulse_class = CLS_ONE;
    end

endmodule

// File: rtl/ir_frame_decoder.sv
// Assembles NEC-style IR frames (addr, ~addr, cmd, ~cmd, LSB first) from
// classified pulses and hands validated address/command pairs downstream.
//   clk, rst_n   : clock, async active-low reset
//   ir           : raw IR line
//   pulse_data   : counter level for a logic-1 pulse
//   pulse_read   : counter level for a leader pulse
//   pulse_error  : counter level for timeout / abort
//   address      : last valid address byte
//   command      : last valid command byte
//   frame_valid  : one-cycle strobe, address/command updated
//   frame_err    : one-cycle strobe, frame aborted or rejected
//   busy         : high while a frame is being received
//
// state   | meaning
// IDLE    | waiting for a leader pulse, other pulses ignored
// RECEIVE | shifting in data bits, aborts on timeout or a new leader
// CHECK   | one cycle, result strobe of the completed frame is visible
module ir_frame_decoder
    import ir_pkg::*;
#(
    parameter int unsigned FRAME_BITS    = DEFAULT_FRAME_BITS,
    parameter bit          CHECK_INVERSE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ir,
    input  logic              pulse_data,
    input  logic              pulse_read,
    input  logic              pulse_error,
    output logic [ADDR_W-1:0] address,
    output logic [CMD_W-1:0]  command,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    ir_state_t               state;
    logic [FRAME_BITS-1:0]   shift;
    logic [FRAME_BITS-1:0]   shift_nxt;
    logic [5:0]              bit_cnt;
    logic                    pulse_end;
    pulse_class_t            pulse_class;

    ir_pulse_classifier u_classifier (
        .clk         (clk),
        .rst_n       (rst_n),
        .ir          (ir),
        .pulse_data  (pulse_data),
        .pulse_read  (pulse_read),
        .pulse_error (pulse_error),
        .pulse_end   (pulse_end),
        .pulse_class (pulse_class)
    );

    assign shift_nxt = {(pulse_class == CLS_ONE), shift[FRAME_BITS-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            address     <= '0;
            command     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pulse_end && pulse_class == CLS_LEADER) begin
                        state   <= RECEIVE;
                        shift   <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                RECEIVE: begin
                    // Timeout does not wait for the pulse to end.
                    if (pulse_error || (pulse_end && pulse_class == CLS_ERR)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (pulse_end) begin
                        if (pulse_class == CLS_LEADER) begin
                            frame_err <= 1'b1;
                            shift     <= '0;
                            bit_cnt   <= '0;
                        end else begin
                            shift   <= shift_nxt;
                            bit_cnt <= bit_cnt + 6'd1;
                            // The verdict is registered on entry to CHECK so
                            // the strobe lands one clock after the last bit.
                            if (bit_cnt == LAST_BIT) begin
                                state <= CHECK;
                                busy  <= 1'b0;
                                if (!CHECK_INVERSE || inverse_ok(shift_nxt[31:0])) begin
                                    address     <= shift_nxt[7:0];
                                    command     <= shift_nxt[23:16];
                                    frame_valid <= 1'b1;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end
                        end
                    end
                end
                CHECK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ir_frame_decoder.md
Name: ir_frame_decoder

Overview:
- Sits directly downstream of the IR pulse-width counter.
- Consumes its three threshold levels (`data` = count > 1000, `read` = count > 1800, `error` = count > 177127), classifies each completed high pulse on the IR line, and assembles a 32-bit NEC-style frame (addr, ~addr, cmd, ~cmd, LSB first).
- Presents a validated address/command pair with a one-cycle strobe to the command handler.

Parameters:
- FRAME_BITS, 32, number of data pulses per frame after the leader
- CHECK_INVERSE, 1, when 1 the inverse bytes must match the true bytes or the frame is rejected

Ports:
- clk  input  1  system clock; same clock as the pulse-width counter
- rst_n  input  1  asynchronous active-low reset
- ir  input  1  raw IR line (the counter's clear input); asynchronous, synchronized internally
- pulse_data  input  1  counter `data` level; high pulse classified as logic 1
- pulse_read  input  1  counter `read` level; high pulse is a frame leader
- pulse_error  input  1  counter `error` level; long idle / abort
- address  output  8  last valid address byte
- command  output  8  last valid command byte
- frame_valid  output  1  one-cycle strobe; address/command updated this cycle
- frame_err  output  1  one-cycle strobe; frame aborted or rejected
- busy  output  1  high while in RECEIVE

Behaviour:
- Reset (rst_n low, asynchronous) clears everything:
  - outputs: address=0, command=0, frame_valid=0, frame_err=0, busy=0
  - internal: state=IDLE, shift=0, bit_cnt=0, sticky flags=0, synchronizer=0
- IR synchronizer:
  - 2-flop synchronizer gives ir_s. An extra flop gives ir_d.
  - pulse_end = ir_d & ~ir_s, i.e. the cycle after ir_s falls. This is 3 clk after the raw fall.
- Sticky capture:
  - The counter's levels clear immediately when ir falls, so they are gone before pulse_end.
  - Each cycle: st_data |= pulse_data, st_read |= pulse_read, st_err |= pulse_error.
  - All three sticky flags clear in the cycle after pulse_end is processed.
  - Levels are monotonic within a pulse, so the sticky OR captures the pulse's maximum class.
- Classification at pulse_end, priority error > read > data > zero:
  - ERR: st_err
  - LEADER: st_read & ~st_err
  - ONE: st_data & ~st_read & ~st_err
  - ZERO: otherwise
- States:
  - IDLE, busy=0:
    - LEADER -> RECEIVE; shift=0, bit_cnt=0.
    - All other classes ignored, with no frame_err.
  - RECEIVE, busy=1:
    - ONE/ZERO: shift = {bit, shift[31:1]} (LSB first); bit_cnt++.
    - If bit_cnt reaches FRAME_BITS -> CHECK.
    - LEADER mid-frame: discard partial, frame_err=1 for one cycle, restart RECEIVE with shift=0, bit_cnt=0.
    - ERR at pulse_end, or pulse_error high at any cycle: frame_err=1, go to IDLE. This is the timeout abort and does not wait for pulse_end.
  - CHECK, one cycle:
    - Frame passes if CHECK_INVERSE=0, or if shift[15:8]==~shift[7:0] and shift[31:24]==~shift[23:16].
    - Pass: address=shift[7:0], command=shift[23:16], frame_valid=1 this cycle.
    - Fail: frame_err=1; address/command hold.
    - Always -> IDLE.
- Timing and holding:
  - Latency: frame_valid is asserted exactly 1 clk after the pulse_end of the 32nd bit.
  - address/command hold until the next valid frame.
- Simultaneous events:
  - pulse_error asserting in the same cycle as pulse_end in RECEIVE is treated as ERR.
  - frame_valid and frame_err never assert together.
- Reset mid-frame: immediate return to IDLE. No strobes are generated on reset release.
- Widths: bit_cnt is 6 bits and saturation is not needed, since CHECK leaves at FRAME_BITS. shift is FRAME_BITS wide.

Decomposition:
- Package ir_pkg:
  - typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} ir_state_t
  - typedef enum logic [1:0] {CLS_ZERO, CLS_ONE, CLS_LEADER, CLS_ERR} pulse_class_t
  - localparams DEFAULT_FRAME_BITS=32, ADDR_W=8, CMD_W=8
- Sub-module ir_pulse_classifier: synchronizer, edge detect, sticky flags, pulse_end and class output. The FSM and shifter stay in ir_frame_decoder.

Test Plan:
- Leader then 32 pulses encoding addr=0x04, cmd=0x08 (ONE pulses hold `data` only, ZERO pulses hold none) -> frame_valid=1 for one clk, 1 clk after the 32nd pulse_end; address=0x04, command=0x08; busy falls.
- Same frame with byte 1 = 0xFA instead of 0xFB -> frame_err=1 for one clk, no frame_valid, address/command keep prior values.
- Leader plus 10 bits, then pulse_error asserted while ir stays high -> frame_err the next clk, state IDLE, busy=0; a following ZERO pulse produces no strobe.
- Leader plus 20 bits, then a second leader and a full valid frame (addr=0x10, cmd=0x55) -> one frame_err at the second leader, then frame_valid with 0x10/0x55.
- ONE/ZERO pulses with no leader in IDLE -> no strobes, busy=0, shift unchanged.
- rst_n low during bit 17 -> outputs and state cleared immediately; after release, a full valid frame decodes correctly.
